// File: rtl/k_sort_pkg.sv
// Shared types and helpers for the streaming k-sorter.
// Latency: n/a (package only).
// Backpressure: n/a.
package k_sort_pkg;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CLEAR = 2'd2
    } state_e;

    // Requested result count folded into the legal range 1..depth.
    function automatic logic [31:0] clamp_k(input logic [31:0] k_raw, input logic [31:0] depth);
        logic [31:0] res;
        res = k_raw;
        if (k_raw == 32'd0) begin
            res = 32'd1;
        end else if (k_raw > depth) begin
            res = depth;
        end
        return res;
    endfunction

endpackage

// File: rtl/k_sort_cell.sv
// One slot of the sorted array: holds valid/id/key, decides whether a new key outranks it.
// Latency: loads or shifts on the cycle a word is accepted.
// Backpressure: none; the parent only pulses ins_en on accepted words.
module k_sort_cell
    import k_sort_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ID_W       = 16,
    parameter int DESCENDING = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clr,
    input  logic              ins_en,
    input  logic [DATA_W-1:0] new_dat,
    input  logic [ID_W-1:0]   new_id,
    input  logic              prev_take,
    input  logic              prev_vld,
    input  logic [ID_W-1:0]   prev_id,
    input  logic [DATA_W-1:0] prev_dat,
    output logic              take,
    output logic              vld,
    output logic [ID_W-1:0]   id,
    output logic [DATA_W-1:0] dat
);

    logic              vld_q, vld_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [DATA_W-1:0] dat_q, dat_d;

    // Strict compare keeps equal keys in arrival order; empty slots always yield.
    always_comb begin
        take = 1'b1;
        if (vld_q) begin
            take = (DESCENDING != 0) ? (new_dat > dat_q) : (new_dat < dat_q);
        end
    end

    always_comb begin
        vld_d = vld_q;
        id_d  = id_q;
        dat_d = dat_q;
        if (clr) begin
            vld_d = 1'b0;
            id_d  = '0;
            dat_d = '0;
        end else if (ins_en && take) begin
            if (prev_take) begin
                vld_d = prev_vld;
                id_d  = prev_id;
                dat_d = prev_dat;
            end else begin
                vld_d = 1'b1;
                id_d  = new_id;
                dat_d = new_dat;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= 1'b0;
            id_q  <= '0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            id_q  <= id_d;
            dat_q <= dat_d;
        end
    end

    assign vld = vld_q;
    assign id  = id_q;
    assign dat = dat_q;

endmodule

// File: rtl/k_sorter_stream.sv
// Frame-based top-k sorter: inserts each word into a sorted slot array, then drains k results.
// Latency: word sorted on acceptance; first result valid the cycle after in_last is accepted.
// Backpressure: in_ready only while filling; drain holds outputs while out_ready is low.
module k_sorter_stream
    import k_sort_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ID_W       = 16,
    parameter int DEPTH      = 128,
    parameter int DESCENDING = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [31:0]       k,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_value,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ID_W-1:0]   out_id,
    output logic [DATA_W-1:0] out_value,
    output logic              out_last,
    output logic              overflow
);

    localparam int          PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] DEPTH_L = 32'(DEPTH);

    state_e            state_q, state_d;
    logic [ID_W-1:0]   id_cnt_q, id_cnt_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic              overflow_q, overflow_d;
    logic              started_q, started_d;
    logic [31:0]       k_q, k_d;

    logic [DEPTH-1:0]  slot_vld;
    logic [DEPTH-1:0]  slot_take;
    logic [ID_W-1:0]   slot_id  [DEPTH];
    logic [DATA_W-1:0] slot_dat [DEPTH];

    logic              accept;
    logic              clr;
    logic [31:0]       occ;
    logic [31:0]       n_out;
    logic              unused_tail_take;

    assign accept           = in_valid && in_ready;
    assign clr              = (state_q == ST_CLEAR);
    assign unused_tail_take = slot_take[DEPTH-1];

    for (genvar g = 0; g < DEPTH; g++) begin : g_cell
        logic              prev_take;
        logic              prev_vld;
        logic [ID_W-1:0]   prev_id;
        logic [DATA_W-1:0] prev_dat;

        if (g == 0) begin : g_head
            assign prev_take = 1'b0;
            assign prev_vld  = 1'b0;
            assign prev_id   = '0;
            assign prev_dat  = '0;
        end else begin : g_body
            assign prev_take = slot_take[g-1];
            assign prev_vld  = slot_vld[g-1];
            assign prev_id   = slot_id[g-1];
            assign prev_dat  = slot_dat[g-1];
        end

        k_sort_cell #(
            .DATA_W    (DATA_W),
            .ID_W      (ID_W),
            .DESCENDING(DESCENDING)
        ) u_cell (
            .clk      (clk),
            .reset_n  (reset_n),
            .clr      (clr),
            .ins_en   (accept),
            .new_dat  (in_value),
            .new_id   (id_cnt_q),
            .prev_take(prev_take),
            .prev_vld (prev_vld),
            .prev_id  (prev_id),
            .prev_dat (prev_dat),
            .take     (slot_take[g]),
            .vld      (slot_vld[g]),
            .id       (slot_id[g]),
            .dat      (slot_dat[g])
        );
    end

    // Valid slots are always packed at the top, so the count is the occupied rank range.
    always_comb begin
        occ = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ = occ + {31'd0, slot_vld[i]};
        end
        n_out = (k_q < occ) ? k_q : occ;
    end

    assign in_ready  = (state_q == ST_FILL);
    assign out_valid = (state_q == ST_DRAIN);
    assign out_last  = out_valid && ((32'(rd_ptr_q) + 32'd1) == n_out);
    assign out_id    = slot_id[rd_ptr_q];
    assign out_value = slot_dat[rd_ptr_q];
    assign overflow  = overflow_q;

    always_comb begin
        state_d    = state_q;
        id_cnt_d   = id_cnt_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        started_d  = started_q;
        k_d        = k_q;
        case (state_q)
            ST_FILL: begin
                if (accept) begin
                    id_cnt_d  = id_cnt_q + 1'b1;
                    started_d = 1'b1;
                    if (!started_q) begin
                        k_d = clamp_k(k, DEPTH_L);
                    end
                    // A full array means this word pushes the frame past DEPTH.
                    if (slot_vld[DEPTH-1]) begin
                        overflow_d = 1'b1;
                    end
                    if (in_last) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (out_ready) begin
                    if (out_last) begin
                        state_d = ST_CLEAR;
                    end else begin
                        rd_ptr_d = rd_ptr_q + 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
                state_d    = ST_FILL;
                id_cnt_d   = '0;
                rd_ptr_d   = '0;
                overflow_d = 1'b0;
                started_d  = 1'b0;
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_FILL;
            id_cnt_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            started_q  <= 1'b0;
            k_q        <= 32'd1;
        end else begin
            state_q    <= state_d;
            id_cnt_q   <= id_cnt_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
            started_q  <= started_d;
            k_q        <= k_d;
        end
    end

endmodule

// File: tb/tb_k_sorter_stream.sv
// Drives identical frames into three sorter configurations and checks each against a frame-level model.
// Latency: n/a (bench).
// Backpressure: exercised by holding out_ready low during one drain.
module tb_k_sorter_stream;

    localparam int NDUT = 3;
    localparam int EMAX = 256;

    logic clk;
    logic reset_n;
    logic [31:0] k;
    logic in_valid;
    logic in_last;
    logic [31:0] in_value;
    logic out_ready;

    logic [NDUT-1:0] in_ready;
    logic [NDUT-1:0] out_valid;
    logic [NDUT-1:0] out_last;
    logic [NDUT-1:0] overflow;
    logic [15:0] out_id [NDUT];
    logic [31:0] out_value [NDUT];

    int cfg_desc  [NDUT] = '{0, 1, 0};
    int cfg_depth [NDUT] = '{128, 128, 4};

    logic [15:0] e_id   [NDUT][EMAX];
    logic [31:0] e_val  [NDUT][EMAX];
    logic        e_last [NDUT][EMAX];
    logic        e_ovf  [NDUT][EMAX];
    int wr_p [NDUT];
    int rd_p [NDUT];
    int post [NDUT];

    logic [31:0] fw [32];
    int fn;
    int errors;
    int checks;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    k_sorter_stream u_dut0 (
        .clk(clk), .reset_n(reset_n), .k(k), .in_valid(in_valid), .in_ready(in_ready[0]),
        .in_value(in_value), .in_last(in_last), .out_valid(out_valid[0]), .out_ready(out_ready),
        .out_id(out_id[0]), .out_value(out_value[0]), .out_last(out_last[0]), .overflow(overflow[0])
    );

    k_sorter_stream #(.DESCENDING(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .k(k), .in_valid(in_valid), .in_ready(in_ready[1]),
        .in_value(in_value), .in_last(in_last), .out_valid(out_valid[1]), .out_ready(out_ready),
        .out_id(out_id[1]), .out_value(out_value[1]), .out_last(out_last[1]), .overflow(overflow[1])
    );

    k_sorter_stream #(.DEPTH(4)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .k(k), .in_valid(in_valid), .in_ready(in_ready[2]),
        .in_value(in_value), .in_last(in_last), .out_valid(out_valid[2]), .out_ready(out_ready),
        .out_id(out_id[2]), .out_value(out_value[2]), .out_last(out_last[2]), .overflow(overflow[2])
    );

    task automatic check(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL dut%0d %s: got %0h expected %0h", d, name, act, exp);
        end
    endtask

    function automatic bit ranks_before(input int desc, input logic [31:0] a, input logic [31:0] b);
        return (desc != 0) ? (a > b) : (a < b);
    endfunction

    // Whole-frame model: stable selection sort, truncated to min(clamped k, frame size, depth).
    task automatic model_frame(input logic [31:0] kin);
        for (int d = 0; d < NDUT; d++) begin
            int depth;
            int kc;
            int keep;
            bit used [32];
            depth = cfg_depth[d];
            kc = (kin == 32'd0) ? 1 : ((kin > 32'(depth)) ? depth : int'(kin));
            keep = kc;
            if (fn < keep) keep = fn;
            if (depth < keep) keep = depth;
            for (int i = 0; i < 32; i++) used[i] = 1'b0;
            for (int r = 0; r < keep; r++) begin
                int best;
                best = -1;
                for (int i = 0; i < fn; i++) begin
                    if (!used[i] && (best < 0 || ranks_before(cfg_desc[d], fw[i], fw[best]))) best = i;
                end
                used[best] = 1'b1;
                e_id[d][wr_p[d]]   = 16'(best);
                e_val[d][wr_p[d]]  = fw[best];
                e_last[d][wr_p[d]] = (r == keep - 1);
                e_ovf[d][wr_p[d]]  = (fn > depth);
                wr_p[d]++;
            end
        end
    endtask

    task automatic send_word(input logic [31:0] v, input logic last);
        int t;
        t = 0;
        while (in_ready != {NDUT{1'b1}} && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        check("in_ready_timeout", 0, 64'(t >= 500), 64'd0);
        in_valid = 1'b1;
        in_value = v;
        in_last  = last;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic run_frame(input logic [31:0] kin, input int hold);
        int t;
        k = kin;
        model_frame(kin);
        out_ready = (hold == 0);
        for (int i = 0; i < fn; i++) send_word(fw[i], i == fn - 1);
        if (hold > 0) begin
            repeat (hold) @(posedge clk);
            #1;
            out_ready = 1'b1;
        end
        t = 0;
        while ((out_valid != '0 || in_ready != {NDUT{1'b1}}) && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        check("drain_timeout", 0, 64'(t >= 500), 64'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state();
        for (int d = 0; d < NDUT; d++) begin
            check("rst_in_ready", d, 64'(in_ready[d]), 64'd1);
            check("rst_out_valid", d, 64'(out_valid[d]), 64'd0);
            check("rst_out_last", d, 64'(out_last[d]), 64'd0);
            check("rst_overflow", d, 64'(overflow[d]), 64'd0);
            check("rst_out_id", d, 64'(out_id[d]), 64'd0);
            check("rst_out_value", d, 64'(out_value[d]), 64'd0);
        end
    endtask

    // Every cycle a result is presented it must equal the model's next entry, whether or not it is taken.
    always @(negedge clk) begin
        if (!reset_n) begin
            for (int d = 0; d < NDUT; d++) post[d] = 0;
        end else begin
            for (int d = 0; d < NDUT; d++) begin
                if (post[d] == 1) begin
                    check("clear_in_ready", d, 64'(in_ready[d]), 64'd0);
                    check("clear_out_valid", d, 64'(out_valid[d]), 64'd0);
                    post[d] = 2;
                end else if (post[d] == 2) begin
                    check("refill_in_ready", d, 64'(in_ready[d]), 64'd1);
                    check("refill_overflow", d, 64'(overflow[d]), 64'd0);
                    post[d] = 0;
                end
                if (out_valid[d]) begin
                    if (rd_p[d] >= wr_p[d]) begin
                        check("unexpected_result", d, 64'(out_value[d]), 64'hdead);
                    end else begin
                        int p;
                        p = rd_p[d];
                        check("out_id", d, 64'(out_id[d]), 64'(e_id[d][p]));
                        check("out_value", d, 64'(out_value[d]), 64'(e_val[d][p]));
                        check("out_last", d, 64'(out_last[d]), 64'(e_last[d][p]));
                        check("overflow", d, 64'(overflow[d]), 64'(e_ovf[d][p]));
                        check("drain_in_ready", d, 64'(in_ready[d]), 64'd0);
                        if (out_ready) begin
                            rd_p[d]++;
                            if (e_last[d][p]) post[d] = 1;
                        end
                    end
                end
            end
        end
    end

    initial begin
        int b;
        errors = 0;
        checks = 0;
        for (int d = 0; d < NDUT; d++) begin
            wr_p[d] = 0;
            rd_p[d] = 0;
        end
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_value  = '0;
        k         = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state();
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Ascending k=3 with a duplicate key.
        fn = 5; fw[0] = 5; fw[1] = 1; fw[2] = 4; fw[3] = 1; fw[4] = 9;
        b = wr_p[0];
        run_frame(32'd3, 0);
        check("pin_f1_id0", 0, 64'(e_id[0][b]), 64'd1);
        check("pin_f1_v0", 0, 64'(e_val[0][b]), 64'd1);
        check("pin_f1_id1", 0, 64'(e_id[0][b+1]), 64'd3);
        check("pin_f1_v1", 0, 64'(e_val[0][b+1]), 64'd1);
        check("pin_f1_id2", 0, 64'(e_id[0][b+2]), 64'd2);
        check("pin_f1_v2", 0, 64'(e_val[0][b+2]), 64'd4);
        check("pin_f1_last", 0, 64'(e_last[0][b+2]), 64'd1);

        // Descending with an all-ones key.
        fn = 3; fw[0] = 32'd7; fw[1] = 32'hFFFF_FFFF; fw[2] = 32'd3;
        b = wr_p[1];
        run_frame(32'd2, 0);
        check("pin_f2_id0", 1, 64'(e_id[1][b]), 64'd1);
        check("pin_f2_v0", 1, 64'(e_val[1][b]), 64'hFFFF_FFFF);
        check("pin_f2_id1", 1, 64'(e_id[1][b+1]), 64'd0);
        check("pin_f2_v1", 1, 64'(e_val[1][b+1]), 64'd7);
        check("pin_f2_cnt", 1, 64'(wr_p[1] - b), 64'd2);

        // Overflow on the 4-deep instance, k above depth, consumer stalls 5 cycles.
        fn = 6; fw[0] = 6; fw[1] = 5; fw[2] = 4; fw[3] = 3; fw[4] = 2; fw[5] = 1;
        b = wr_p[2];
        run_frame(32'd10, 5);
        check("pin_f3_cnt", 2, 64'(wr_p[2] - b), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check("pin_f3_val", 2, 64'(e_val[2][b+i]), 64'(i + 1));
            check("pin_f3_id", 2, 64'(e_id[2][b+i]), 64'(5 - i));
            check("pin_f3_ovf", 2, 64'(e_ovf[2][b+i]), 64'd1);
        end
        check("pin_f3_last", 2, 64'(e_last[2][b+3]), 64'd1);

        // k=0 clamps to one result.
        fn = 1; fw[0] = 32'd42;
        b = wr_p[0];
        run_frame(32'd0, 0);
        check("pin_f4_cnt", 0, 64'(wr_p[0] - b), 64'd1);
        check("pin_f4_id", 0, 64'(e_id[0][b]), 64'd0);
        check("pin_f4_v", 0, 64'(e_val[0][b]), 64'd42);
        check("pin_f4_last", 0, 64'(e_last[0][b]), 64'd1);

        // Ties must come out in arrival order.
        fn = 5; fw[0] = 3; fw[1] = 3; fw[2] = 2; fw[3] = 3; fw[4] = 2;
        run_frame(32'd5, 0);

        // Reset mid-frame abandons the partial frame.
        k = 32'd4;
        send_word(32'd11, 1'b0);
        send_word(32'd12, 1'b0);
        send_word(32'd13, 1'b0);
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state();
        reset_n = 1'b1;
        @(posedge clk); #1;
        fn = 1; fw[0] = 32'd8;
        b = wr_p[0];
        run_frame(32'd1, 0);
        check("pin_f6_id", 0, 64'(e_id[0][b]), 64'd0);
        check("pin_f6_v", 0, 64'(e_val[0][b]), 64'd8);

        repeat (5) @(posedge clk);
        #1;
        for (int d = 0; d < NDUT; d++) begin
            check("all_consumed", d, 64'(rd_p[d]), 64'(wr_p[d]));
            check("idle_out_valid", d, 64'(out_valid[d]), 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
